// File: rtl/case_2_mul_pkg.sv
// Shared definitions for the pipelined multiply/accumulate block.
//   acc_op_t   : accumulator operation carried with every transaction
//   MAX_STAGE  : deepest supported pipeline
//   prod_width : full product width for two operand widths
package case_2_mul_pkg;

    typedef enum logic [1:0] {
        PASS = 2'b00,
        LOAD = 2'b01,
        ACC  = 2'b10
    } acc_op_t;

    localparam int MAX_STAGE = 8;

    function automatic int prod_width(input int a, input int b);
        return a + b;
    endfunction

endpackage

// File: rtl/case_2_mul_sat_acc.sv
// Final-stage accumulator with saturation.
//   clk, rst_n : clock and synchronous active-low reset
//   en         : a valid transaction is loading the final stage this cycle
//   op         : accumulator operation (PASS / LOAD / ACC, 2'b11 acts as PASS)
//   prod       : exact PROD_W-bit product of the transaction
//   prod_sgn   : product is signed (either operand was signed)
//   acc        : accumulator value after the most recent transaction
//   sat        : the most recent transaction clamped the accumulator
module case_2_mul_sat_acc
    import case_2_mul_pkg::*;
#(
    parameter int PROD_W = 13,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [1:0]        op,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_sgn,
    output logic [ACC_W-1:0]  acc,
    output logic              sat
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Size casts both truncate and zero-extend; the mask marks the bits that
    // came from the product so the rest can be filled with its sign.
    function automatic logic signed [ACC_W-1:0] ext_prod(input logic [PROD_W-1:0] p,
                                                         input logic s);
        logic [ACC_W-1:0] mask;
        mask = ACC_W'({PROD_W{1'b1}});
        if (s && p[PROD_W-1])
            return ACC_W'(p) | ~mask;
        return ACC_W'(p);
    endfunction

    // One guard bit is enough: overflow shows as disagreement of the top two bits.
    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W:0] s);
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? ACC_MIN : ACC_MAX;
        return s[ACC_W-1:0];
    endfunction

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [ACC_W:0]   sum;
    logic                    sat_nxt;

    always_comb begin
        prod_ext = ext_prod(prod, prod_sgn);
        sum      = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
        acc_nxt  = acc;
        sat_nxt  = 1'b0;
        case (op)
            LOAD: acc_nxt = prod_ext;
            ACC: begin
                acc_nxt = sat_add(sum);
                sat_nxt = sum[ACC_W] ^ sum[ACC_W-1];
            end
            default: ; // PASS and the unused encoding leave the accumulator alone
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (en) begin
            acc <= acc_nxt;
            sat <= sat_nxt;
        end
    end

endmodule

// File: rtl/case_2_mul_pipe_acc.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control and a
// saturating accumulator in the final stage.
//   ap_clk, ap_rst_n : clock and synchronous active-low reset
//   in_vld, in_rdy   : input handshake (in_rdy is the pipeline advance enable)
//   din0, din1       : operands; sgn0/sgn1 select signed interpretation
//   acc_op           : PASS / LOAD / ACC for this transaction
//   out_vld, out_rdy : output handshake
//   dout             : product resized to dout_WIDTH
//   acc_dout         : accumulator after this transaction
//   acc_sat          : this transaction saturated the accumulator
module case_2_mul_pipe_acc
    import case_2_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 8,
    parameter int din1_WIDTH = 5,
    parameter int dout_WIDTH = 13,
    parameter int ACC_WIDTH  = 20
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  sgn0,
    input  logic                  sgn1,
    input  logic [1:0]            acc_op,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [dout_WIDTH-1:0] dout,
    output logic [ACC_WIDTH-1:0]  acc_dout,
    output logic                  acc_sat
);

    localparam int P = prod_width(din0_WIDTH, din1_WIDTH);

    if (NUM_STAGE < 1 || NUM_STAGE > MAX_STAGE || ACC_WIDTH < dout_WIDTH) begin : g_bad_cfg
        $error("case_2_mul_pipe_acc ID=%0d: NUM_STAGE or ACC_WIDTH out of range", ID);
    end

    function automatic logic [dout_WIDTH-1:0] resize_dout(input logic [P-1:0] p,
                                                          input logic s);
        logic [dout_WIDTH-1:0] mask;
        mask = dout_WIDTH'({P{1'b1}});
        if (s && p[P-1])
            return dout_WIDTH'(p) | ~mask;
        return dout_WIDTH'(p);
    endfunction

    logic                ce;
    logic signed [P-1:0] a_wide;
    logic signed [P-1:0] b_wide;
    logic        [P-1:0] prod_c;
    logic                prod_sgn_c;

    logic                fin_vld;
    logic        [P-1:0] fin_prod;
    logic                fin_sgn;
    logic        [1:0]   fin_op;
    logic                load_fin;

    assign ce     = !out_vld | out_rdy;
    assign in_rdy = ce;

    // Only the low P bits of the product are kept, and those depend only on
    // the low P bits of each extended operand, so a P x P multiply suffices.
    always_comb begin
        a_wide     = {{din1_WIDTH{sgn0 & din0[din0_WIDTH-1]}}, din0};
        b_wide     = {{din0_WIDTH{sgn1 & din1[din1_WIDTH-1]}}, din1};
        prod_c     = a_wide * b_wide;
        prod_sgn_c = sgn0 | sgn1;
    end

    if (NUM_STAGE > 1) begin : g_pipe
        localparam int D = NUM_STAGE - 1;

        logic         vld_p  [D];
        logic [P-1:0] prod_p [D];
        logic         sgn_p  [D];
        logic [1:0]   op_p   [D];

        // Stage 1 captures the product; later stages only carry it for retiming
        always_ff @(posedge ap_clk) begin
            if (!ap_rst_n) begin
                for (int i = 0; i < D; i++) vld_p[i] <= 1'b0;
            end else if (ce) begin
                vld_p[0] <= in_vld;
                for (int i = 1; i < D; i++) vld_p[i] <= vld_p[i-1];
            end
        end

        always_ff @(posedge ap_clk) begin
            if (ce) begin
                prod_p[0] <= prod_c;
                sgn_p[0]  <= prod_sgn_c;
                op_p[0]   <= acc_op;
                for (int i = 1; i < D; i++) begin
                    prod_p[i] <= prod_p[i-1];
                    sgn_p[i]  <= sgn_p[i-1];
                    op_p[i]   <= op_p[i-1];
                end
            end
        end

        assign fin_vld  = vld_p[D-1];
        assign fin_prod = prod_p[D-1];
        assign fin_sgn  = sgn_p[D-1];
        assign fin_op   = op_p[D-1];
    end else begin : g_comb
        assign fin_vld  = in_vld;
        assign fin_prod = prod_c;
        assign fin_sgn  = prod_sgn_c;
        assign fin_op   = acc_op;
    end

    assign load_fin = ce & fin_vld;

    // Final stage: output register and accumulator
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            out_vld <= 1'b0;
            dout    <= '0;
        end else if (ce) begin
            out_vld <= fin_vld;
            if (fin_vld)
                dout <= resize_dout(fin_prod, fin_sgn);
        end
    end

    case_2_mul_sat_acc #(
        .PROD_W (P),
        .ACC_W  (ACC_WIDTH)
    ) u_sat_acc (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .en       (load_fin),
        .op       (fin_op),
        .prod     (fin_prod),
        .prod_sgn (fin_sgn),
        .acc      (acc_dout),
        .sat      (acc_sat)
    );

endmodule

// File: tb/tb_case_2_mul_pipe_acc.sv
`timescale 1ns/1ps
module tb_case_2_mul_pipe_acc;

    localparam int NS = 3;
    localparam int W0 = 8;
    localparam int W1 = 5;
    localparam int DW = 13;
    localparam int AW = 20;
    localparam int AMAX = (1 << (AW - 1)) - 1;
    localparam int AMIN = -(1 << (AW - 1));

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld;
    logic          in_rdy;
    logic [W0-1:0] din0;
    logic [W1-1:0] din1;
    logic          sgn0;
    logic          sgn1;
    logic [1:0]    acc_op;
    logic          out_vld;
    logic          out_rdy;
    logic [DW-1:0] dout;
    logic [AW-1:0] acc_dout;
    logic          acc_sat;

    always #5 clk = ~clk;

    case_2_mul_pipe_acc #(
        .ID(1), .NUM_STAGE(NS), .din0_WIDTH(W0), .din1_WIDTH(W1),
        .dout_WIDTH(DW), .ACC_WIDTH(AW)
    ) dut (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
        .din0(din0), .din1(din1), .sgn0(sgn0), .sgn1(sgn1), .acc_op(acc_op),
        .out_vld(out_vld), .out_rdy(out_rdy), .dout(dout),
        .acc_dout(acc_dout), .acc_sat(acc_sat)
    );

    typedef struct {
        logic [DW-1:0] dout;
        logic [AW-1:0] acc;
        logic          sat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   model_acc = 0;
    int   nout = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int as_int(input int v, input int w, input logic s);
        if (s && v >= (1 << (w - 1))) return v - (1 << w);
        return v;
    endfunction

    // Reference model: exact integer product, accumulator clamped to AW-bit signed range
    task automatic push_model(input logic [W0-1:0] a, input logic [W1-1:0] b,
                              input logic s0, input logic s1, input logic [1:0] op);
        int   p;
        int   sum;
        exp_t e;
        p     = as_int(int'(a), W0, s0) * as_int(int'(b), W1, s1);
        e.dout = DW'(p);
        e.sat  = 1'b0;
        case (op)
            2'b01: model_acc = p;
            2'b10: begin
                sum = model_acc + p;
                if (sum > AMAX) begin
                    model_acc = AMAX;
                    e.sat = 1'b1;
                end else if (sum < AMIN) begin
                    model_acc = AMIN;
                    e.sat = 1'b1;
                end else begin
                    model_acc = sum;
                end
            end
            default: ;
        endcase
        e.acc = AW'(model_acc);
        sb.push_back(e);
    endtask

    // Output monitor: compare the head of the scoreboard whenever a result is
    // presented; it is only retired when the consumer takes it.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_vld === 1'b1) begin
            checks++;
            assert (sb.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_output observed dout=%0h expected none", dout);
            end
            if (sb.size() > 0) begin
                check($sformatf("out%0d_dout", nout), 32'(dout), 32'(sb[0].dout));
                check($sformatf("out%0d_acc", nout), 32'(acc_dout), 32'(sb[0].acc));
                check($sformatf("out%0d_sat", nout), 32'(acc_sat), 32'(sb[0].sat));
                if (out_rdy === 1'b1) begin
                    void'(sb.pop_front());
                    nout++;
                end
            end
        end
    end

    task automatic send(input logic [W0-1:0] a, input logic [W1-1:0] b,
                        input logic s0, input logic s1, input logic [1:0] op);
        int guard = 0;
        in_vld = 1'b1;
        din0   = a;
        din1   = b;
        sgn0   = s0;
        sgn1   = s1;
        acc_op = op;
        @(negedge clk);
        while (in_rdy !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        assert (guard < 50) else begin
            failures++;
            $error("FAIL accept_timeout observed in_rdy=%b expected 1", in_rdy);
        end
        if (guard < 50) push_model(a, b, s0, s1, op);
        @(posedge clk);
        #1;
        in_vld = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        do begin
            @(posedge clk);
            guard++;
        end while (sb.size() > 0 && guard < 100);
        #1;
        check({tag, "_drain_pending"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        in_vld = 1'b0;
        out_rdy = 1'b1;
        din0 = '0; din1 = '0; sgn0 = 1'b0; sgn1 = 1'b0; acc_op = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_out_vld", 32'(out_vld), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_acc", 32'(acc_dout), 32'd0);
        check("rst_sat", 32'(acc_sat), 32'd0);
        check("rst_in_rdy", 32'(in_rdy), 32'd1);
        @(posedge clk);
        #1;

        // Signed x signed with latency check
        send(8'h80, 5'h10, 1'b1, 1'b1, 2'b00);
        for (int i = 1; i <= NS; i++) begin
            @(negedge clk);
            check($sformatf("latency_c%0d", i), 32'(out_vld), 32'(i == NS));
        end
        drain("t1");
        check("t1_dout_const", 32'(dout), 32'h0800);

        // Mixed signedness
        send(8'hFF, 5'h1F, 1'b0, 1'b0, 2'b00);
        send(8'hFF, 5'h1F, 1'b0, 1'b1, 2'b00);
        drain("t2");
        check("t2_dout_const", 32'(dout), 32'h1F01);

        // Accumulate: 1000, 985, 970, 955
        send(8'd100, 5'd10, 1'b1, 1'b1, 2'b01);
        repeat (3) send(8'd5, 5'h1D, 1'b1, 1'b1, 2'b10);
        drain("t3");
        check("t3_acc_const", 32'(acc_dout), 32'd955);
        check("t3_sat_const", 32'(acc_sat), 32'd0);

        // Saturation on the 256th transaction, then PASS clears acc_sat
        send(8'h80, 5'h10, 1'b1, 1'b1, 2'b01);
        repeat (255) send(8'h80, 5'h10, 1'b1, 1'b1, 2'b10);
        send(8'h80, 5'h10, 1'b1, 1'b1, 2'b00);
        drain("t4");
        check("t4_acc_clamp", 32'(acc_dout), 32'h7FFFF);
        check("t4_sat_pass", 32'(acc_sat), 32'd0);

        // Back-pressure mid-stream
        fork
            begin
                for (int k = 0; k < 10; k++)
                    send(W0'(k * 7 + 1), W1'(k - 4), 1'b1, 1'b1, (k == 0) ? 2'b01 : 2'b10);
            end
            begin
                repeat (NS + 2) @(posedge clk);
                #2 out_rdy = 1'b0;
                #1;
                check("t5_stall_out_vld", 32'(out_vld), 32'd1);
                check("t5_stall_in_rdy", 32'(in_rdy), 32'd0);
                repeat (5) @(posedge clk);
                #2 out_rdy = 1'b1;
                #1;
                check("t5_release_in_rdy", 32'(in_rdy), 32'd1);
            end
        join
        drain("t5");

        // Reset mid-stream discards in-flight work
        send(8'd2, 5'd2, 1'b0, 1'b0, 2'b01);
        send(8'd1, 5'd1, 1'b0, 1'b0, 2'b10);
        rst_n = 1'b0;
        sb.delete();
        model_acc = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i <= NS; i++) begin
            @(negedge clk);
            check($sformatf("t6_flushed_c%0d", i), 32'(out_vld), 32'd0);
        end
        @(posedge clk);
        #1;
        send(8'd3, 5'd3, 1'b0, 1'b0, 2'b01);
        drain("t6");
        check("t6_acc_const", 32'(acc_dout), 32'd9);
        check("t6_dout_const", 32'(dout), 32'd9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
